spi_slave_mem: RTL and testbench

SPI_SLAVE_MEM -- requirements
Module: spi_slave_mem

---
 rtl/spi_slave_mem.sv | 202 ++++++++++++++++++++
 tb/tb_spi_slave_mem.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_mem.sv
// SPI mode-0 slave bridging serial write/read commands onto a byte-wide
// memory port with auto-incrementing address and read prefetch.
module spi_slave_mem #(
  parameter int         ADDR_W    = 8,
  parameter logic [7:0] CMD_WRITE = 8'h02,
  parameter logic [7:0] CMD_READ  = 8'h03
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              spi_sck_i,
  input  logic              spi_csn_i,
  input  logic              spi_mosi_i,
  output logic              spi_miso_o,
  output logic              spi_miso_oe_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [7:0]        mem_wdata_o,
  input  logic [7:0]        mem_rdata_i,
  output logic              frame_done_o,
  output logic              cmd_err_o
);

  localparam int MAXB  = (ADDR_W > 8) ? ADDR_W : 8;
  localparam int CNT_W = $clog2(MAXB);
  localparam int RX_W  = MAXB - 1;
  // Synchronizer lanes are {mosi, csn, sck}; csn idles high.
  localparam logic [2:0] SYNC_RST = 3'b010;

  typedef enum logic [2:0] {IDLE, CMD, ADDR, WDATA, RDATA, IGNORE} state_t;

  logic [2:0] sync_in, sync1_q, sync2_q;
  logic       sck_prev_q, csn_prev_q;
  logic       sck_s, csn_s, mosi_s;
  logic       sck_rise, sck_fall, csn_rise, csn_fall;

  assign sync_in = {spi_mosi_i, spi_csn_i, spi_sck_i};
  assign sck_s   = sync2_q[0];
  assign csn_s   = sync2_q[1];
  assign mosi_s  = sync2_q[2];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q    <= SYNC_RST;
      sync2_q    <= SYNC_RST;
      sck_prev_q <= 1'b0;
      csn_prev_q <= 1'b1;
    end else begin
      sync1_q    <= sync_in;
      sync2_q    <= sync1_q;
      sck_prev_q <= sck_s;
      csn_prev_q <= csn_s;
    end
  end

  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;
  assign csn_rise = csn_s & ~csn_prev_q;
  assign csn_fall = ~csn_s & csn_prev_q;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [RX_W-1:0]    rx_q, rx_d;
  logic               is_read_q, is_read_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [7:0]         tx_q, tx_d;
  logic               miso_q, miso_d;
  logic               req_q, req_d;
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [7:0]         wdata_q, wdata_d;
  logic               cap_q, cap_d;
  logic               frame_done_q, frame_done_d;
  logic               cmd_err_q, cmd_err_d;
  logic [7:0]         rx_byte;
  logic [ADDR_W-1:0]  rx_addr;

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    rx_d         = rx_q;
    is_read_d    = is_read_q;
    addr_d       = addr_q;
    tx_d         = tx_q;
    miso_d       = miso_q;
    req_d        = 1'b0;
    we_d         = 1'b0;
    mem_addr_d   = mem_addr_q;
    wdata_d      = wdata_q;
    cap_d        = req_q & ~we_q;
    frame_done_d = 1'b0;
    cmd_err_d    = 1'b0;
    rx_byte      = {rx_q[6:0], mosi_s};
    rx_addr      = {rx_q[ADDR_W-2:0], mosi_s};

    // Read data is valid exactly one cycle after a read strobe.
    if (cap_q) tx_d = mem_rdata_i;

    if (csn_rise) begin
      state_d      = IDLE;
      bit_cnt_d    = '0;
      frame_done_d = 1'b1;
    end else if (state_q == IDLE) begin
      if (csn_fall) begin
        state_d   = CMD;
        bit_cnt_d = '0;
      end
    end else if (sck_rise) begin
      rx_d      = {rx_q[RX_W-2:0], mosi_s};
      bit_cnt_d = bit_cnt_q + CNT_W'(1);
      case (state_q)
        CMD: if (bit_cnt_q == CNT_W'(7)) begin
          bit_cnt_d = '0;
          if (rx_byte == CMD_WRITE || rx_byte == CMD_READ) begin
            state_d   = ADDR;
            is_read_d = (rx_byte == CMD_READ);
          end else begin
            state_d   = IGNORE;
            cmd_err_d = 1'b1;
          end
        end
        ADDR: if (bit_cnt_q == CNT_W'(ADDR_W - 1)) begin
          bit_cnt_d = '0;
          if (is_read_q) begin
            // First read goes out at once so the byte is ready before the next falling edge.
            state_d    = RDATA;
            req_d      = 1'b1;
            mem_addr_d = rx_addr;
            addr_d     = rx_addr + ADDR_W'(1);
          end else begin
            state_d = WDATA;
            addr_d  = rx_addr;
          end
        end
        WDATA: if (bit_cnt_q == CNT_W'(7)) begin
          bit_cnt_d  = '0;
          req_d      = 1'b1;
          we_d       = 1'b1;
          mem_addr_d = addr_q;
          wdata_d    = rx_byte;
          addr_d     = addr_q + ADDR_W'(1);
        end
        RDATA: if (bit_cnt_q == CNT_W'(7)) begin
          bit_cnt_d  = '0;
          req_d      = 1'b1;
          mem_addr_d = addr_q;
          addr_d     = addr_q + ADDR_W'(1);
        end
        default: bit_cnt_d = '0;
      endcase
    end else if (sck_fall && state_q == RDATA) begin
      miso_d = tx_q[7];
      tx_d   = {tx_q[6:0], 1'b0};
    end

    if (state_d != RDATA) miso_d = 1'b0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      rx_q         <= '0;
      is_read_q    <= 1'b0;
      addr_q       <= '0;
      tx_q         <= '0;
      miso_q       <= 1'b0;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      mem_addr_q   <= '0;
      wdata_q      <= '0;
      cap_q        <= 1'b0;
      frame_done_q <= 1'b0;
      cmd_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      rx_q         <= rx_d;
      is_read_q    <= is_read_d;
      addr_q       <= addr_d;
      tx_q         <= tx_d;
      miso_q       <= miso_d;
      req_q        <= req_d;
      we_q         <= we_d;
      mem_addr_q   <= mem_addr_d;
      wdata_q      <= wdata_d;
      cap_q        <= cap_d;
      frame_done_q <= frame_done_d;
      cmd_err_q    <= cmd_err_d;
    end
  end

  assign spi_miso_oe_o = (state_q == RDATA);
  assign spi_miso_o    = miso_q & spi_miso_oe_o;
  assign mem_req_o     = req_q;
  assign mem_we_o      = we_q;
  assign mem_addr_o    = mem_addr_q;
  assign mem_wdata_o   = wdata_q;
  assign frame_done_o  = frame_done_q;
  assign cmd_err_o     = cmd_err_q;

endmodule

// File: tb/tb_spi_slave_mem.sv
// Randomized scoreboard bench for spi_slave_mem: an SPI master task drives
// frames, a reference model queues expected memory/MISO traffic, a monitor checks it.
module tb_spi_slave_mem;

  localparam int HALF = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sck = 1'b0;
  logic       csn = 1'b1;
  logic       mosi = 1'b0;
  logic       spi_miso_o, spi_miso_oe_o, mem_req_o, mem_we_o;
  logic [7:0] mem_addr_o, mem_wdata_o;
  logic [7:0] mem_rdata = 8'h00;
  logic       frame_done_o, cmd_err_o;

  spi_slave_mem dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .spi_sck_i    (sck),
    .spi_csn_i    (csn),
    .spi_mosi_i   (mosi),
    .spi_miso_o   (spi_miso_o),
    .spi_miso_oe_o(spi_miso_oe_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_rdata_i  (mem_rdata),
    .frame_done_o (frame_done_o),
    .cmd_err_o    (cmd_err_o)
  );

  always #5 clk = ~clk;

  // Scoreboard state
  int          compared = 0;
  int          mismatched = 0;
  logic [15:0] exp_wr_q[$];
  logic [7:0]  exp_ra_q[$];
  logic [7:0]  exp_rd_q[$];
  int          exp_frames = 0;
  int          exp_errs = 0;
  logic        allow_oe = 1'b0;
  int          rst_chk_req = 0;
  int          frm_chk_req = 0;
  logic [7:0]  ref_mem[256];

  // Frame under construction
  logic [7:0]  frm[8];
  int          frm_len, frm_tail;

  function automatic logic [7:0] preload(input int i);
    return 8'((i * 73 + 29) & 255);
  endfunction

  // Memory attached to the DUT: data valid only the cycle after a read strobe.
  initial begin
    logic [7:0] tb_mem[256];
    for (int i = 0; i < 256; i++) tb_mem[i] = preload(i);
    forever begin
      @(posedge clk);
      if (mem_req_o && mem_we_o) tb_mem[mem_addr_o] = mem_wdata_o;
      if (mem_req_o && !mem_we_o) mem_rdata <= tb_mem[mem_addr_o];
      else mem_rdata <= 8'($urandom);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: the only process that compares.
  initial begin
    int         rst_seen = 0;
    int         frm_seen = 0;
    logic       prev_req = 1'b0;
    logic       sck_seen = 1'b0;
    int         rise_cnt = 0;
    int         miso_nb = 0;
    logic [7:0] miso_sh = 8'h00;
    int         fd_cnt = 0;
    int         err_cnt = 0;
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (rst_chk_req != rst_seen) begin
        rst_seen = rst_chk_req;
        chk("rst_miso", {31'd0, spi_miso_o}, 0);
        chk("rst_oe", {31'd0, spi_miso_oe_o}, 0);
        chk("rst_req", {31'd0, mem_req_o}, 0);
        chk("rst_we", {31'd0, mem_we_o}, 0);
        chk("rst_addr", {24'd0, mem_addr_o}, 0);
        chk("rst_wdata", {24'd0, mem_wdata_o}, 0);
        chk("rst_frame_done", {31'd0, frame_done_o}, 0);
        chk("rst_cmd_err", {31'd0, cmd_err_o}, 0);
      end
      if (!rst) begin
        chk("miso_without_oe", {31'd0, spi_miso_o & ~spi_miso_oe_o}, 0);
        chk("oe_outside_read", {31'd0, spi_miso_oe_o & ~allow_oe}, 0);
        if (mem_req_o) begin
          chk("req_back_to_back", {31'd0, prev_req}, 0);
          if (mem_we_o) begin
            e = (exp_wr_q.size() > 0) ? {16'd0, exp_wr_q.pop_front()} : 'x;
            chk("write_addr_data", {16'd0, mem_addr_o, mem_wdata_o}, e);
          end else begin
            e = (exp_ra_q.size() > 0) ? {24'd0, exp_ra_q.pop_front()} : 'x;
            chk("read_addr", {24'd0, mem_addr_o}, e);
          end
        end
        prev_req = mem_req_o;
        if (csn) begin
          rise_cnt = 0;
          miso_nb  = 0;
        end else if (sck && !sck_seen) begin
          chk("oe_at_rise", {31'd0, spi_miso_oe_o}, {31'd0, allow_oe && rise_cnt >= 16});
          rise_cnt++;
          if (spi_miso_oe_o) begin
            miso_sh = {miso_sh[6:0], spi_miso_o};
            miso_nb++;
            if (miso_nb == 8) begin
              miso_nb = 0;
              e = (exp_rd_q.size() > 0) ? {24'd0, exp_rd_q.pop_front()} : 'x;
              chk("miso_byte", {24'd0, miso_sh}, e);
            end
          end
        end
        if (frame_done_o) fd_cnt++;
        if (cmd_err_o) err_cnt++;
      end else begin
        prev_req = 1'b0;
      end
      sck_seen = sck;
      if (frm_chk_req != frm_seen) begin
        frm_seen = frm_chk_req;
        chk("writes_missing", exp_wr_q.size(), 0);
        chk("reads_missing", exp_ra_q.size(), 0);
        chk("miso_bytes_missing", exp_rd_q.size(), 0);
        chk("frame_done_count", fd_cnt, exp_frames);
        chk("cmd_err_count", err_cnt, exp_errs);
        exp_wr_q.delete();
        exp_ra_q.delete();
        exp_rd_q.delete();
      end
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic spi_bits(input logic [7:0] v, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      mosi = v[7-i];
      wait_clks(HALF);
      sck = 1'b1;
      wait_clks(HALF);
      sck = 1'b0;
    end
  endtask

  task automatic set_frame(input logic [7:0] b0, b1, b2, b3, input int len, input int tail);
    frm[0] = b0; frm[1] = b1; frm[2] = b2; frm[3] = b3;
    for (int i = 4; i < 8; i++) frm[i] = 8'($urandom);
    frm_len  = len;
    frm_tail = tail;
  endtask

  // Reference model: what a whole frame should do, from command semantics alone.
  task automatic model_frame();
    logic [7:0] a;
    exp_frames++;
    if (frm[0] != 8'h02 && frm[0] != 8'h03) begin
      exp_errs++;
    end else if (frm_len >= 2) begin
      a = frm[1];
      for (int i = 2; i < frm_len; i++) begin
        if (frm[0] == 8'h02) begin
          exp_wr_q.push_back({a, frm[i]});
          ref_mem[a] = frm[i];
        end else begin
          exp_ra_q.push_back(a);
          exp_rd_q.push_back(ref_mem[a]);
        end
        a = a + 8'd1;
      end
      if (frm[0] == 8'h03) exp_ra_q.push_back(a);
    end
  endtask

  task automatic run_frame();
    model_frame();
    allow_oe = (frm[0] == 8'h03) && (frm_len >= 2);
    csn = 1'b0;
    wait_clks(HALF);
    for (int i = 0; i < frm_len; i++) spi_bits(frm[i], 8);
    if (frm_tail > 0) spi_bits(8'($urandom), frm_tail);
    wait_clks(HALF);
    csn = 1'b1;
    wait_clks(20);
    allow_oe = 1'b0;
    frm_chk_req++;
    wait_clks(3);
  endtask

  initial begin
    int r, len;
    logic [7:0] cmd;
    for (int i = 0; i < 256; i++) ref_mem[i] = preload(i);

    wait_clks(3);
    rst_chk_req++;
    wait_clks(3);
    rst = 1'b0;
    wait_clks(5);

    set_frame(8'h02, 8'h10, 8'hA5, 8'h5A, 4, 0); run_frame();
    set_frame(8'h03, 8'h10, 8'h00, 8'h00, 4, 0); run_frame();
    set_frame(8'h02, 8'hFF, 8'h11, 8'h22, 4, 0); run_frame();
    set_frame(8'h9F, 8'h00, 8'h00, 8'h00, 3, 0); run_frame();
    set_frame(8'h02, 8'h20, 8'h00, 8'h00, 2, 5); run_frame();
    set_frame(8'h02, 8'h10, 8'hA5, 8'h5A, 4, 0); run_frame();

    // Reset in the middle of a read, just after the first data MSB is driven.
    exp_ra_q.push_back(8'h10);
    allow_oe = 1'b1;
    csn = 1'b0;
    wait_clks(HALF);
    spi_bits(8'h03, 8);
    spi_bits(8'h10, 8);
    wait_clks(4);
    rst = 1'b1;
    rst_chk_req++;
    wait_clks(2);
    csn = 1'b1;
    wait_clks(5);
    rst = 1'b0;
    wait_clks(5);
    allow_oe = 1'b0;
    frm_chk_req++;
    wait_clks(3);
    set_frame(8'h03, 8'h10, 8'h00, 8'h00, 4, 0); run_frame();

    for (int n = 0; n < 14; n++) begin
      r = $urandom_range(0, 9);
      cmd = (r < 4) ? 8'h02 : (r < 8) ? 8'h03 : 8'($urandom_range(4, 255));
      len = $urandom_range(1, 6);
      set_frame(cmd, (n % 4 == 0) ? 8'hFE : 8'($urandom), 8'($urandom), 8'($urandom), len,
                (r % 3 == 0) ? $urandom_range(1, 7) : 0);
      run_frame();
    end

    wait_clks(5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
